mmio_intc: RTL
==============

# mmio_intc

Parametrised, memory-mapped interrupt controller on the CPU data bus. It generalises the single vector register and enable logic at the top level into NCH prioritised sources, each with its own vector, enable bit and pending latch. It has a request/acknowledge/end-of-interrupt handshake toward the CPU. It decodes its own address window, and the top-level read mux selects its `r_data` when `hit` is high.

## Interface
Parameters:
- NCH, 4, number of interrupt sources, 1..8
- BASE_ADDR, 8'd240, first byte address of the register window; the window is 4+NCH bytes and must not overlap the other peripheral addresses

Ports (one clock; reset is synchronous and active-high):
- wb_clk_i  in  1  clock; all state changes on its rising edge
- wb_rst_i  in  1  synchronous active-high reset
- addr  in  8  CPU data address (rs_data)
- w_data  in  8  CPU write data (rd_data)
- w_en  in  1  CPU memory write strobe
- src  in  NCH  interrupt source lines, synchronous to wb_clk_i
- int_ack  in  1  CPU accepted the request (one-cycle pulse)
- r_data  out  8  read data for `addr`; combinational; 0 when not hit
- hit  out  1  `addr` lies inside the window; combinational
- int_req  out  1  interrupt request to the CPU; registered
- int_vec  out  8  jump vector for the request; registered; valid while int_req=1

## Operation
Register map (offsets from BASE_ADDR):
- +0 ENABLE: RW, bit i enables channel i; bits at or above NCH read 0.
- +1 PENDING: R, plus write-1-to-clear.
- +2 STATUS: R, {in_service, int_req, 3'b0, active_id[2:0]}.
- +3 EOI: W; any write ends service. Reads return 0.
- +4+i VEC[i]: RW, 8-bit vector for channel i.

A write happens when w_en=1 and hit=1. It takes effect at the next edge.

Pending update per cycle: pending[i] <= (pending[i] & ~clr[i]) | set[i]. clr is either the W1C write bit or the ack clear of the active channel. If set and clear occur in the same cycle, set wins.

FSM states:
- IDLE: if any bit of (pending & ENABLE) is set, pick the lowest set index as active_id. Latch int_vec <= VEC[active_id], set int_req <= 1 and go to REQ.
- REQ: int_req is held. On int_ack=1: clear pending[active_id], set int_req <= 0 and go to SERVICE. If ENABLE[active_id] is cleared before the ack: withdraw, set int_req <= 0 and go to IDLE; the pending bit is kept.
- SERVICE: in_service=1 and no new request is raised (no nesting). An EOI write returns the FSM to IDLE. int_ack in this state is ignored.
- A VEC write during REQ does not alter the latched int_vec.

Reset: all registers are cleared to 0 and the FSM enters IDLE. Outputs after reset: int_req=0, int_vec=0, r_data=0 for an unmapped addr, STATUS=0. Reset applied in REQ or SERVICE drops int_req on the same edge.

## Timing
- Write to any register: visible on r_data in the cycle after the w_en edge.
- Source to request latency (pending already enabled):
  - Edge k samples src high, so pending=1 after edge k.
  - int_req=1 after edge k+1.
- int_ack sampled at edge m: int_req=0 and pending cleared after edge m.
- EOI at edge m: FSM is in IDLE after edge m. The next request can appear after edge m+1.
- int_req falls in the cycle after the withdraw condition is seen.

## Configuration
- INTC_EDGE_EN defined:
  - src is registered (reset 0).
  - set[i] = src[i] & ~src_q[i]; pending latches rising edges only.
  - A level held high sets pending once.
- INTC_EDGE_EN undefined (level mode):
  - set[i] = src[i]; pending re-asserts every cycle the source stays high.
  - W1C and ack are effective only once the source has dropped.

## Test plan
- Reset, then read the window with NCH=4, BASE=240 -> ENABLE=0, PENDING=0, STATUS=0, VEC0..3=0, int_req=0. Reads at addr 239 and 248 -> hit=0, r_data=0.
- Write VEC2=8'h40 and ENABLE=8'h04, pulse src[2] -> int_req=1 two edges after src, int_vec=8'h40, STATUS=8'h42. Assert int_ack -> int_req=0, STATUS=8'h82. Write EOI -> STATUS=0.
- Enable 8'h0F, raise src[1] and src[3] in the same cycle -> first request uses VEC1. After ack and EOI, a second request uses VEC3.
- In SERVICE, raise src[0] (enabled) -> no int_req until EOI. int_req=1 the cycle after EOI.
- In REQ for channel 2, write ENABLE=0 -> int_req drops, PENDING bit2 stays 1. Assert wb_rst_i in SERVICE -> all state is 0 on the next edge.
- Hold src[0] high for 10 cycles; W1C PENDING=8'h01, then ack:
  - with INTC_EDGE_EN: exactly one request; pending stays 0 after the clear.
  - without INTC_EDGE_EN: pending is 1 again the cycle after each clear.

Source files
------------

// File: rtl/mmio_intc.sv
// Memory-mapped prioritised interrupt controller: NCH sources, per-channel vector/enable/pending,
// req/ack/EOI handshake. Define INTC_EDGE_EN for rising-edge source detection (default: level).
module mmio_intc #(
  parameter int unsigned NCH       = 4,
  parameter logic [7:0]  BASE_ADDR = 8'd240
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic [7:0]     addr,
  input  logic [7:0]     w_data,
  input  logic           w_en,
  input  logic [NCH-1:0] src,
  input  logic           int_ack,
  output logic [7:0]     r_data,
  output logic           hit,
  output logic           int_req,
  output logic [7:0]     int_vec
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  localparam logic [8:0] WIN_END = 9'(BASE_ADDR) + 9'(4 + NCH);

  state_e         state_q, state_d;
  logic [NCH-1:0] enable_q, enable_d;
  logic [NCH-1:0] pending_q, pending_d;
  logic [7:0]     vec_q [NCH];
  logic [2:0]     active_id_q, active_id_d;
  logic           int_req_q, int_req_d;
  logic [7:0]     int_vec_q, int_vec_d;

  logic [7:0]     offset;
  logic           wr, wr_enable, wr_pending, wr_eoi;
  logic [NCH-1:0] wr_vec;
  logic [NCH-1:0] set, clr, masked, active_onehot;
  logic [2:0]     pick;
  logic [7:0]     picked_vec;
  logic           active_en, in_service;

  assign hit        = ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < WIN_END);
  assign offset     = addr - BASE_ADDR;
  assign wr         = w_en && hit;
  assign wr_enable  = wr && (offset == 8'd0);
  assign wr_pending = wr && (offset == 8'd1);
  assign wr_eoi     = wr && (offset == 8'd3);
  assign in_service = (state_q == SERVICE);

`ifdef INTC_EDGE_EN
  logic [NCH-1:0] src_q;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) src_q <= '0;
    else          src_q <= src;
  end
  assign set = src & ~src_q;
`else
  assign set = src;
`endif

  for (genvar gi = 0; gi < NCH; gi++) begin : g_vec
    assign wr_vec[gi]        = wr && (offset == 8'(4 + gi));
    assign active_onehot[gi] = (active_id_q == 3'(gi));
    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)        vec_q[gi] <= 8'd0;
      else if (wr_vec[gi]) vec_q[gi] <= w_data;
    end
  end

  assign masked    = pending_q & enable_q;
  assign active_en = |(enable_q & active_onehot);

  // Lowest index wins; the vector is selected here so it can be latched on grant.
  always_comb begin
    pick       = 3'd0;
    picked_vec = 8'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (masked[i]) begin
        pick       = 3'(i);
        picked_vec = vec_q[i];
      end
    end
  end

  // Set has priority over both the W1C write and the acknowledge clear.
  always_comb begin
    clr = '0;
    if (wr_pending) clr = w_data[NCH-1:0];
    if (state_q == REQ && int_ack) clr = clr | active_onehot;
    pending_d = (pending_q & ~clr) | set;
    enable_d  = wr_enable ? w_data[NCH-1:0] : enable_q;
  end

  always_comb begin
    state_d     = state_q;
    int_req_d   = int_req_q;
    int_vec_d   = int_vec_q;
    active_id_d = active_id_q;
    case (state_q)
      IDLE: begin
        if (|masked) begin
          state_d     = REQ;
          int_req_d   = 1'b1;
          int_vec_d   = picked_vec;
          active_id_d = pick;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d   = SERVICE;
          int_req_d = 1'b0;
        end else if (!active_en) begin
          state_d     = IDLE;
          int_req_d   = 1'b0;
          active_id_d = 3'd0;
        end
      end
      SERVICE: begin
        if (wr_eoi) begin
          state_d     = IDLE;
          active_id_d = 3'd0;
        end
      end
      default: begin
        state_d   = IDLE;
        int_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      enable_q    <= '0;
      pending_q   <= '0;
      active_id_q <= 3'd0;
      int_req_q   <= 1'b0;
      int_vec_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      pending_q   <= pending_d;
      active_id_q <= active_id_d;
      int_req_q   <= int_req_d;
      int_vec_q   <= int_vec_d;
    end
  end

  always_comb begin
    r_data = 8'd0;
    if (hit) begin
      case (offset)
        8'd0: r_data[NCH-1:0] = enable_q;
        8'd1: r_data[NCH-1:0] = pending_q;
        8'd2: r_data = {in_service, int_req_q, 3'b000, active_id_q};
        default: begin
          for (int i = 0; i < NCH; i++) begin
            if (offset == 8'(4 + i)) r_data = vec_q[i];
          end
        end
      endcase
    end
  end

  assign int_req = int_req_q;
  assign int_vec = int_vec_q;

endmodule
